// File: rtl/opendap_swdio_sequencer.sv
// SWDIO bit sequencer: drives the registered IO flop inputs one cycle ahead of the pad
// and captures read bits from the input flop with its one-cycle lag compensated.
module opendap_swdio_sequencer #(
  parameter  int unsigned W  = 32,
  localparam int unsigned LW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [LW-1:0] cmd_len,
  input  logic          cmd_parity,
  input  logic [W-1:0]  cmd_wdata,
  output logic          rsp_valid,
  output logic [W-1:0]  rsp_rdata,
  output logic          rsp_parity_err,
  output logic          busy,
  output logic          dp_swdo_next,
  output logic          dp_swdo_en_next,
  input  logic          dp_swdi_prev
);

  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_e;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01, OP_TURN = 2'b10, OP_IDLE = 2'b11} op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic          par_en_q, par_en_d;
  logic [LW:0]   rem_q, rem_d;
  logic [LW-1:0] dcnt_q, dcnt_d;
  logic [W-1:0]  sh_q, sh_d;
  logic          wpar_q, wpar_d;
  logic          swdo_q, swdo_d;
  logic          en_q, en_d;

  // Read-cycle tags travel one stage behind the op so capture can overlap the next command.
  logic          rd_v_q, rd_v_d, rd_first_q, rd_first_d;
  logic          rd_par_q, rd_par_d, rd_last_q, rd_last_d;
  logic          stb_v_q, stb_first_q, stb_par_q, stb_last_q;

  logic [W-1:0]  cap_q, cap_d, cap_tmp;
  logic [LW-1:0] idx_q, idx_d, idx_tmp;
  logic          err_tmp;
  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [W-1:0]  mask;
  logic          accept;

  assign cmd_ready       = ~rst & ((state_q == S_IDLE) | (rem_q == '0));
  assign accept          = cmd_valid & cmd_ready;
  assign busy            = (state_q == S_SHIFT) | stb_v_q;
  assign dp_swdo_next    = swdo_q;
  assign dp_swdo_en_next = en_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_parity_err  = rsp_err_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    par_en_d   = par_en_q;
    rem_d      = rem_q;
    dcnt_d     = dcnt_q;
    sh_d       = sh_q;
    wpar_d     = wpar_q;
    swdo_d     = 1'b0;
    en_d       = 1'b0;
    rd_v_d     = 1'b0;
    rd_first_d = 1'b0;
    rd_par_d   = 1'b0;
    rd_last_d  = 1'b0;
    mask       = '1;
    if (state_q == S_SHIFT && rem_q != '0) begin
      rem_d = rem_q - (LW+1)'(1);
      if (dcnt_q != '0) dcnt_d = dcnt_q - LW'(1);
      sh_d = sh_q >> 1;
      case (op_q)
        OP_WRITE: begin
          en_d   = 1'b1;
          swdo_d = (dcnt_q != '0) ? sh_q[0] : wpar_q;
        end
        OP_READ: begin
          rd_v_d    = 1'b1;
          rd_par_d  = par_en_q & (dcnt_q == '0);
          rd_last_d = (rem_q == (LW+1)'(1));
        end
        OP_TURN: ;
        OP_IDLE: en_d = 1'b1;
      endcase
    end else if (accept) begin
      state_d  = S_SHIFT;
      op_d     = op_e'(cmd_op);
      par_en_d = cmd_parity & ~cmd_op[1];
      rem_d    = {1'b0, cmd_len} + (LW+1)'(cmd_parity & ~cmd_op[1]);
      dcnt_d   = cmd_len;
      sh_d     = cmd_wdata >> 1;
      mask     = mask >> (LW'(W - 1) - cmd_len);
      wpar_d   = ^(cmd_wdata & mask);
      case (op_e'(cmd_op))
        OP_WRITE: begin
          en_d   = 1'b1;
          swdo_d = cmd_wdata[0];
        end
        OP_READ: begin
          rd_v_d     = 1'b1;
          rd_first_d = 1'b1;
          rd_last_d  = (cmd_len == '0) & ~cmd_parity;
        end
        OP_TURN: ;
        OP_IDLE: en_d = 1'b1;
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  // The first strobe of a read restarts the shift register, so back-to-back reads never mix.
  always_comb begin
    cap_d       = cap_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cap_tmp     = stb_first_q ? '0 : cap_q;
    idx_tmp     = stb_first_q ? '0 : idx_q;
    err_tmp     = 1'b0;
    if (stb_v_q) begin
      if (stb_par_q) begin
        err_tmp = dp_swdi_prev ^ (^cap_tmp);
      end else begin
        cap_tmp[idx_tmp] = dp_swdi_prev;
        idx_tmp          = idx_tmp + LW'(1);
      end
      cap_d = cap_tmp;
      idx_d = idx_tmp;
      if (stb_last_q) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = cap_tmp;
        rsp_err_d   = err_tmp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WRITE;
      par_en_q    <= 1'b0;
      rem_q       <= '0;
      dcnt_q      <= '0;
      sh_q        <= '0;
      wpar_q      <= 1'b0;
      swdo_q      <= 1'b0;
      en_q        <= 1'b0;
      rd_v_q      <= 1'b0;
      rd_first_q  <= 1'b0;
      rd_par_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      stb_v_q     <= 1'b0;
      stb_first_q <= 1'b0;
      stb_par_q   <= 1'b0;
      stb_last_q  <= 1'b0;
      cap_q       <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      par_en_q    <= par_en_d;
      rem_q       <= rem_d;
      dcnt_q      <= dcnt_d;
      sh_q        <= sh_d;
      wpar_q      <= wpar_d;
      swdo_q      <= swdo_d;
      en_q        <= en_d;
      rd_v_q      <= rd_v_d;
      rd_first_q  <= rd_first_d;
      rd_par_q    <= rd_par_d;
      rd_last_q   <= rd_last_d;
      stb_v_q     <= rd_v_q;
      stb_first_q <= rd_first_q;
      stb_par_q   <= rd_par_q;
      stb_last_q  <= rd_last_q;
      cap_q       <= cap_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_opendap_swdio_sequencer.sv
// Directed, table-driven bench for opendap_swdio_sequencer; cycle k = k-th period after the accept edge.
module tb_opendap_swdio_sequencer;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [4:0]    cmd_len = '0;
  logic          cmd_parity = 1'b0;
  logic [W-1:0]  cmd_wdata = '0;
  logic          rsp_valid;
  logic [W-1:0]  rsp_rdata;
  logic          rsp_parity_err;
  logic          busy;
  logic          dp_swdo_next;
  logic          dp_swdo_en_next;
  logic          dp_swdi_prev = 1'b0;

  int unsigned total = 0;
  int unsigned bad   = 0;

  opendap_swdio_sequencer #(.W(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_len         (cmd_len),
    .cmd_parity      (cmd_parity),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_parity_err  (rsp_parity_err),
    .busy            (busy),
    .dp_swdo_next    (dp_swdo_next),
    .dp_swdo_en_next (dp_swdo_en_next),
    .dp_swdi_prev    (dp_swdi_prev)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  len;
    logic        par;
    logic [31:0] wdata;
    int unsigned L;
    logic [33:0] bits;
    logic        en;
  } wvec_t;

  typedef struct {
    logic [4:0]  len;
    logic        par;
    logic [31:0] data;
    logic        pbit;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } rvec_t;

  wvec_t wv[8];
  rvec_t rv[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned n, L, pulses;
    logic [7:0]  seq;
    logic [7:0]  wb;

    wv[0] = '{2'b00, 5'd7,  1'b1, 32'h0000_00A5, 9,  34'h0A5,         1'b1};
    wv[1] = '{2'b00, 5'd3,  1'b0, 32'hFFFF_FFF6, 4,  34'h6,           1'b1};
    wv[2] = '{2'b00, 5'd31, 1'b1, 32'h8000_0001, 33, 34'h0_8000_0001, 1'b1};
    wv[3] = '{2'b00, 5'd0,  1'b1, 32'h0000_0001, 2,  34'h3,           1'b1};
    wv[4] = '{2'b00, 5'd4,  1'b1, 32'h0000_000B, 6,  34'h2B,          1'b1};
    wv[5] = '{2'b11, 5'd3,  1'b1, 32'hFFFF_FFFF, 4,  34'h0,           1'b1};
    wv[6] = '{2'b10, 5'd1,  1'b1, 32'hFFFF_FFFF, 2,  34'h0,           1'b0};
    wv[7] = '{2'b11, 5'd0,  1'b0, 32'h0,         1,  34'h0,           1'b1};

    rv[0] = '{5'd31, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0};
    rv[1] = '{5'd31, 1'b1, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1};
    rv[2] = '{5'd3,  1'b0, 32'hFFFF_FFFA, 1'b0, 32'h0000_000A, 1'b0};
    rv[3] = '{5'd0,  1'b1, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b1};
    rv[4] = '{5'd7,  1'b1, 32'h0000_003C, 1'b0, 32'h0000_003C, 1'b0};

    // reset state
    #12;
    chk("rst_ready", 64'(cmd_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_en", 64'(dp_swdo_en_next), 64'(0));
    chk("rst_swdo", 64'(dp_swdo_next), 64'(0));
    chk("rst_rspv", 64'(rsp_valid), 64'(0));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_err", 64'(rsp_parity_err), 64'(0));
    tick;
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(cmd_ready), 64'(1));
    tick;

    // write / turn / idle table
    for (int i = 0; i < 8; i++) begin
      cmd_op = wv[i].op; cmd_len = wv[i].len; cmd_parity = wv[i].par; cmd_wdata = wv[i].wdata;
      cmd_valid = 1'b1;
      chk($sformatf("w%0d_ready0", i), 64'(cmd_ready), 64'(1));
      tick;
      cmd_valid = 1'b0;
      for (int unsigned k = 1; k <= wv[i].L; k++) begin
        chk($sformatf("w%0d_swdo_c%0d", i, k), 64'(dp_swdo_next), 64'(wv[i].bits[k-1]));
        chk($sformatf("w%0d_en_c%0d", i, k), 64'(dp_swdo_en_next), 64'(wv[i].en));
        chk($sformatf("w%0d_ready_c%0d", i, k), 64'(cmd_ready), 64'(k == wv[i].L));
        chk($sformatf("w%0d_busy_c%0d", i, k), 64'(busy), 64'(1));
        tick;
      end
      chk($sformatf("w%0d_en_after", i), 64'(dp_swdo_en_next), 64'(0));
      chk($sformatf("w%0d_swdo_after", i), 64'(dp_swdo_next), 64'(0));
      chk($sformatf("w%0d_ready_after", i), 64'(cmd_ready), 64'(1));
      chk($sformatf("w%0d_busy_after", i), 64'(busy), 64'(0));
    end

    // read table
    for (int i = 0; i < 5; i++) begin
      n = 32'(rv[i].len) + 1;
      L = n + 32'(rv[i].par);
      cmd_op = 2'b01; cmd_len = rv[i].len; cmd_parity = rv[i].par; cmd_wdata = '0;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      for (int unsigned k = 1; k <= L + 1; k++) begin
        if (k >= 2) dp_swdi_prev = (k - 1 <= n) ? rv[i].data[k-2] : rv[i].pbit;
        else        dp_swdi_prev = 1'b0;
        if (k <= L) chk($sformatf("r%0d_en_c%0d", i, k), 64'(dp_swdo_en_next), 64'(0));
        chk($sformatf("r%0d_rspv_c%0d", i, k), 64'(rsp_valid), 64'(0));
        tick;
      end
      dp_swdi_prev = 1'b0;
      chk($sformatf("r%0d_rspv", i), 64'(rsp_valid), 64'(1));
      chk($sformatf("r%0d_rdata", i), 64'(rsp_rdata), 64'(rv[i].exp_rdata));
      chk($sformatf("r%0d_err", i), 64'(rsp_parity_err), 64'(rv[i].exp_err));
      tick;
      chk($sformatf("r%0d_rspv_end", i), 64'(rsp_valid), 64'(0));
      chk($sformatf("r%0d_rdata_hold", i), 64'(rsp_rdata), 64'(rv[i].exp_rdata));
    end

    // gapless chain: WRITE len7 0x3C, TURN len0, READ len2 capturing 3'b101
    wb = 8'h3C;
    cmd_op = 2'b00; cmd_len = 5'd7; cmd_parity = 1'b0; cmd_wdata = 32'h3C;
    cmd_valid = 1'b1;
    tick;
    cmd_op = 2'b10; cmd_len = 5'd0; cmd_parity = 1'b1;
    for (int unsigned k = 1; k <= 14; k++) begin
      if (k == 9) begin cmd_op = 2'b01; cmd_len = 5'd2; cmd_parity = 1'b0; end
      if (k >= 10) cmd_valid = 1'b0;
      dp_swdi_prev = (k == 11) || (k == 13);
      chk($sformatf("ch_en_c%0d", k), 64'(dp_swdo_en_next), 64'(k <= 8));
      chk($sformatf("ch_swdo_c%0d", k), 64'(dp_swdo_next), 64'((k <= 8) ? wb[k-1] : 1'b0));
      chk($sformatf("ch_ready_c%0d", k), 64'(cmd_ready), 64'(k == 8 || k == 9 || k >= 12));
      chk($sformatf("ch_rspv_c%0d", k), 64'(rsp_valid), 64'(k == 14));
      chk($sformatf("ch_busy_c%0d", k), 64'(busy), 64'(k <= 13));
      if (k == 14) chk("ch_rdata", 64'(rsp_rdata), 64'(5));
      tick;
    end
    dp_swdi_prev = 1'b0;

    // back-to-back READ len3: 0xA then 0x5
    seq = 8'h5A;
    cmd_op = 2'b01; cmd_len = 5'd3; cmd_parity = 1'b0;
    cmd_valid = 1'b1;
    tick;
    for (int unsigned k = 1; k <= 11; k++) begin
      if (k == 5) cmd_valid = 1'b0;
      dp_swdi_prev = (k >= 2 && k <= 9) ? seq[k-2] : 1'b0;
      chk($sformatf("bb_rspv_c%0d", k), 64'(rsp_valid), 64'(k == 6 || k == 10));
      chk($sformatf("bb_ready_c%0d", k), 64'(cmd_ready), 64'(k == 4 || k >= 8));
      chk($sformatf("bb_busy_c%0d", k), 64'(busy), 64'(k <= 9));
      if (k >= 6) chk($sformatf("bb_rdata_c%0d", k), 64'(rsp_rdata), 64'((k < 10) ? 32'hA : 32'h5));
      tick;
    end
    dp_swdi_prev = 1'b0;

    // reset during cycle 20 of a 32-bit READ
    cmd_op = 2'b01; cmd_len = 5'd31; cmd_parity = 1'b0;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    for (int unsigned k = 1; k <= 19; k++) begin
      dp_swdi_prev = k[0];
      tick;
    end
    chk("mr_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("mr_ready", 64'(cmd_ready), 64'(0));
    chk("mr_busy", 64'(busy), 64'(0));
    chk("mr_en", 64'(dp_swdo_en_next), 64'(0));
    chk("mr_swdo", 64'(dp_swdo_next), 64'(0));
    chk("mr_rspv", 64'(rsp_valid), 64'(0));
    chk("mr_rdata", 64'(rsp_rdata), 64'(0));
    chk("mr_err", 64'(rsp_parity_err), 64'(0));
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("mr_ready_rel", 64'(cmd_ready), 64'(1));
    chk("mr_busy_rel", 64'(busy), 64'(0));
    pulses = 0;
    for (int unsigned k = 0; k < 40; k++) begin
      tick;
      if (rsp_valid) pulses++;
    end
    chk("mr_no_rspv", 64'(pulses), 64'(0));
    chk("mr_ready_end", 64'(cmd_ready), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
